// File: rtl/sn76489_cmd_decoder_if.sv
// Bus between the serial shift front end and the SN76489 command decoder:
// byte framing inputs plus the decoded tone/noise/attenuation registers.
interface sn76489_cmd_decoder_if;
   logic       SHIFT_EN;
   logic       SYNC;
   logic [7:0] BYTE_IN;
   logic [9:0] TONE0;
   logic [9:0] TONE1;
   logic [9:0] TONE2;
   logic [2:0] NOISE_CTRL;
   logic [3:0] ATTN0;
   logic [3:0] ATTN1;
   logic [3:0] ATTN2;
   logic [3:0] ATTN3;
   logic       NOISE_WR;
   logic       BYTE_DONE;
   logic [2:0] LATCH_Q;

   modport master (
      output SHIFT_EN, SYNC, BYTE_IN,
      input  TONE0, TONE1, TONE2, NOISE_CTRL,
      input  ATTN0, ATTN1, ATTN2, ATTN3,
      input  NOISE_WR, BYTE_DONE, LATCH_Q
   );

   modport slave (
      input  SHIFT_EN, SYNC, BYTE_IN,
      output TONE0, TONE1, TONE2, NOISE_CTRL,
      output ATTN0, ATTN1, ATTN2, ATTN3,
      output NOISE_WR, BYTE_DONE, LATCH_Q
   );
endinterface

// File: rtl/sn76489_cmd_decoder.sv
// SN76489 latch/data command decoder: counts shift strobes, and one cycle after
// a full byte is assembled writes exactly one tone, noise or attenuation register.
module sn76489_cmd_decoder (
   input logic                   CLK,
   input logic                   RST,
   sn76489_cmd_decoder_if.slave  bus
);

   logic [2:0] bit_cnt;
   logic       pending;
   logic [2:0] latch_q;
   logic [9:0] tone0, tone1, tone2;
   logic [2:0] noise_ctrl;
   logic [3:0] attn0, attn1, attn2, attn3;
   logic       noise_wr;
   logic       byte_done;

   logic       is_latch;
   logic [2:0] sel;
   logic [9:0] tone_cur;
   logic [9:0] tone_next;

   // A latch byte addresses its own target; a data byte reuses the last latch.
   always_comb begin
      is_latch = bus.BYTE_IN[7];
      sel      = is_latch ? bus.BYTE_IN[6:4] : latch_q;
      case (sel[2:1])
         2'd0:    tone_cur = tone0;
         2'd1:    tone_cur = tone1;
         default: tone_cur = tone2;
      endcase
      tone_next = is_latch ? {tone_cur[9:4], bus.BYTE_IN[3:0]}
                           : {bus.BYTE_IN[5:0], tone_cur[3:0]};
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         bit_cnt    <= 3'd0;
         pending    <= 1'b0;
         latch_q    <= 3'b000;
         tone0      <= 10'h000;
         tone1      <= 10'h000;
         tone2      <= 10'h000;
         noise_ctrl <= 3'b000;
         attn0      <= 4'hF;
         attn1      <= 4'hF;
         attn2      <= 4'hF;
         attn3      <= 4'hF;
         noise_wr   <= 1'b0;
         byte_done  <= 1'b0;
      end else begin
         byte_done <= 1'b0;
         noise_wr  <= 1'b0;

         // A strobe coinciding with SYNC is bit 0 of a freshly framed byte.
         if (bus.SYNC)
            bit_cnt <= bus.SHIFT_EN ? 3'd1 : 3'd0;
         else if (bus.SHIFT_EN)
            bit_cnt <= bit_cnt + 3'd1;

         if (bus.SHIFT_EN && !bus.SYNC && (bit_cnt == 3'd7))
            pending <= 1'b1;
         else if (pending)
            pending <= 1'b0;

         if (pending) begin
            byte_done <= 1'b1;
            if (is_latch)
               latch_q <= bus.BYTE_IN[6:4];
            if (sel[0]) begin
               case (sel[2:1])
                  2'd0:    attn0 <= bus.BYTE_IN[3:0];
                  2'd1:    attn1 <= bus.BYTE_IN[3:0];
                  2'd2:    attn2 <= bus.BYTE_IN[3:0];
                  default: attn3 <= bus.BYTE_IN[3:0];
               endcase
            end else if (sel[2:1] == 2'd3) begin
               noise_ctrl <= bus.BYTE_IN[2:0];
               noise_wr   <= 1'b1;
            end else begin
               case (sel[2:1])
                  2'd0:    tone0 <= tone_next;
                  2'd1:    tone1 <= tone_next;
                  default: tone2 <= tone_next;
               endcase
            end
         end
      end
   end

   assign bus.TONE0      = tone0;
   assign bus.TONE1      = tone1;
   assign bus.TONE2      = tone2;
   assign bus.NOISE_CTRL = noise_ctrl;
   assign bus.ATTN0      = attn0;
   assign bus.ATTN1      = attn1;
   assign bus.ATTN2      = attn2;
   assign bus.ATTN3      = attn3;
   assign bus.NOISE_WR   = noise_wr;
   assign bus.BYTE_DONE  = byte_done;
   assign bus.LATCH_Q    = latch_q;

endmodule

// File: tb/tb_sn76489_cmd_decoder.sv
// Directed bench for sn76489_cmd_decoder: models the upstream LSB-first shift
// register and checks hand-computed register values after each command byte.
module tb_sn76489_cmd_decoder;

   logic CLK = 1'b0;
   logic RST;
   logic ser = 1'b0;
   logic [7:0] sr = 8'h00;

   int checks = 0;
   int fails = 0;
   int cyc = 0;
   int done_cnt = 0;
   int nw_cnt = 0;
   int misalign = 0;
   int last_done = 0;
   int prev_done = 0;

   sn76489_cmd_decoder_if ifc ();

   sn76489_cmd_decoder dut (
      .CLK (CLK),
      .RST (RST),
      .bus (ifc)
   );

   always #5 CLK = ~CLK;

   // Upstream right shift register: new serial bit enters at the MSB.
   always @(posedge CLK) begin
      if (ifc.SHIFT_EN)
         sr <= {ser, sr[7:1]};
   end
   assign ifc.BYTE_IN = sr;

   // Pulse monitor, sampled just after each rising edge.
   always @(posedge CLK) begin
      cyc = cyc + 1;
      #1;
      if (ifc.BYTE_DONE) begin
         done_cnt  = done_cnt + 1;
         prev_done = last_done;
         last_done = cyc;
      end
      if (ifc.NOISE_WR)
         nw_cnt = nw_cnt + 1;
      if (ifc.NOISE_WR !== ifc.BYTE_DONE)
         misalign = misalign + 1;
   end

   task automatic shift_bit(input logic b, input logic with_sync);
      ifc.SHIFT_EN = 1'b1;
      ifc.SYNC     = with_sync;
      ser          = b;
      @(negedge CLK);
      ifc.SHIFT_EN = 1'b0;
      ifc.SYNC     = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] v, input int maxgap);
      for (int i = 0; i < 8; i++) begin
         if (maxgap > 0)
            repeat ($urandom_range(maxgap, 0)) @(negedge CLK);
         shift_bit(v[i], 1'b0);
      end
   endtask

   task automatic test_reset;
      RST = 1'b1;
      repeat (2) @(negedge CLK);
      checks++;
      if (ifc.TONE0 !== 10'h000 || ifc.TONE1 !== 10'h000 || ifc.TONE2 !== 10'h000) begin
         fails++;
         $display("[TB] FAIL reset_tone: got %h %h %h, expected 000 000 000",
                  ifc.TONE0, ifc.TONE1, ifc.TONE2);
      end
      checks++;
      if ({ifc.ATTN0, ifc.ATTN1, ifc.ATTN2, ifc.ATTN3} !== 16'hFFFF) begin
         fails++;
         $display("[TB] FAIL reset_attn: got %h%h%h%h, expected FFFF",
                  ifc.ATTN0, ifc.ATTN1, ifc.ATTN2, ifc.ATTN3);
      end
      checks++;
      if (ifc.NOISE_CTRL !== 3'b000 || ifc.LATCH_Q !== 3'b000 ||
          ifc.NOISE_WR !== 1'b0 || ifc.BYTE_DONE !== 1'b0) begin
         fails++;
         $display("[TB] FAIL reset_misc: got noise=%b latch=%b nw=%b done=%b, expected 000 000 0 0",
                  ifc.NOISE_CTRL, ifc.LATCH_Q, ifc.NOISE_WR, ifc.BYTE_DONE);
      end
      RST = 1'b0;
      @(negedge CLK);
   endtask

   task automatic test_reset_midbyte;
      int d0;
      d0 = done_cnt;
      repeat (5) shift_bit(1'b1, 1'b0);
      RST = 1'b1;
      @(negedge CLK);
      RST = 1'b0;
      send_byte(8'h9A, 0);
      @(negedge CLK);
      checks++;
      if (ifc.ATTN0 !== 4'hA || ifc.LATCH_Q !== 3'b001) begin
         fails++;
         $display("[TB] FAIL reset_midbyte: got attn0=%h latch=%b, expected A 001",
                  ifc.ATTN0, ifc.LATCH_Q);
      end
      checks++;
      if (done_cnt - d0 !== 1) begin
         fails++;
         $display("[TB] FAIL reset_midbyte_done: got %0d decodes, expected 1", done_cnt - d0);
      end
      // Return ATTN0 to off so later checks see a known state.
      send_byte(8'h9F, 0);
      @(negedge CLK);
   endtask

   task automatic test_tone;
      int d0;
      logic [15:0] bits;
      d0   = done_cnt;
      bits = 16'h0F8E;
      for (int i = 0; i < 16; i++) begin
         shift_bit(bits[i], 1'b0);
         if (i == 8) begin
            checks++;
            if (ifc.TONE0 !== 10'h00E || ifc.BYTE_DONE !== 1'b1) begin
               fails++;
               $display("[TB] FAIL tone_latch: got tone0=%h done=%b, expected 00E 1",
                        ifc.TONE0, ifc.BYTE_DONE);
            end
         end
      end
      @(negedge CLK);
      checks++;
      if (ifc.TONE0 !== 10'h0FE || ifc.BYTE_DONE !== 1'b1) begin
         fails++;
         $display("[TB] FAIL tone_data: got tone0=%h done=%b, expected 0FE 1",
                  ifc.TONE0, ifc.BYTE_DONE);
      end
      @(negedge CLK);
      checks++;
      if (done_cnt - d0 !== 2 || last_done - prev_done !== 8) begin
         fails++;
         $display("[TB] FAIL tone_spacing: got %0d pulses %0d apart, expected 2 pulses 8 apart",
                  done_cnt - d0, last_done - prev_done);
      end
   endtask

   task automatic test_attn;
      send_byte(8'hF3, 0);
      @(negedge CLK);
      checks++;
      if (ifc.ATTN3 !== 4'h3 || ifc.LATCH_Q !== 3'b111) begin
         fails++;
         $display("[TB] FAIL attn_latch: got attn3=%h latch=%b, expected 3 111",
                  ifc.ATTN3, ifc.LATCH_Q);
      end
      send_byte(8'h07, 0);
      @(negedge CLK);
      checks++;
      if (ifc.ATTN3 !== 4'h7 || ifc.LATCH_Q !== 3'b111) begin
         fails++;
         $display("[TB] FAIL attn_data: got attn3=%h latch=%b, expected 7 111",
                  ifc.ATTN3, ifc.LATCH_Q);
      end
      checks++;
      if (ifc.TONE0 !== 10'h0FE || ifc.TONE1 !== 10'h000 || ifc.TONE2 !== 10'h000 ||
          ifc.ATTN0 !== 4'hF) begin
         fails++;
         $display("[TB] FAIL attn_hold: got tone=%h %h %h attn0=%h, expected 0FE 000 000 F",
                  ifc.TONE0, ifc.TONE1, ifc.TONE2, ifc.ATTN0);
      end
   endtask

   task automatic test_noise;
      int n0;
      int m0;
      n0 = nw_cnt;
      m0 = misalign;
      send_byte(8'hE5, 0);
      @(negedge CLK);
      checks++;
      if (ifc.NOISE_CTRL !== 3'b101 || ifc.NOISE_WR !== 1'b1) begin
         fails++;
         $display("[TB] FAIL noise_latch: got ctrl=%b wr=%b, expected 101 1",
                  ifc.NOISE_CTRL, ifc.NOISE_WR);
      end
      repeat (3) @(negedge CLK);
      send_byte(8'h02, 0);
      @(negedge CLK);
      checks++;
      if (ifc.NOISE_CTRL !== 3'b010 || ifc.LATCH_Q !== 3'b110) begin
         fails++;
         $display("[TB] FAIL noise_data: got ctrl=%b latch=%b, expected 010 110",
                  ifc.NOISE_CTRL, ifc.LATCH_Q);
      end
      @(negedge CLK);
      checks++;
      if (nw_cnt - n0 !== 2 || misalign !== m0 || ifc.ATTN3 !== 4'h7) begin
         fails++;
         $display("[TB] FAIL noise_pulses: got %0d wr, %0d misaligned, attn3=%h, expected 2 0 7",
                  nw_cnt - n0, misalign - m0, ifc.ATTN3);
      end
   endtask

   task automatic test_gaps;
      send_byte(8'h8E, 5);
      repeat ($urandom_range(5, 0)) @(negedge CLK);
      send_byte(8'h0F, 5);
      @(negedge CLK);
      checks++;
      if (ifc.TONE0 !== 10'h0FE) begin
         fails++;
         $display("[TB] FAIL gaps_tone0: got %h, expected 0FE", ifc.TONE0);
      end
      send_byte(8'hA5, 5);
      send_byte(8'h3C, 5);
      @(negedge CLK);
      checks++;
      if (ifc.TONE1 !== 10'h3C5 || ifc.TONE0 !== 10'h0FE) begin
         fails++;
         $display("[TB] FAIL gaps_tone1: got tone1=%h tone0=%h, expected 3C5 0FE",
                  ifc.TONE1, ifc.TONE0);
      end
   endtask

   task automatic test_sync;
      repeat (3) shift_bit(1'b1, 1'b0);
      ifc.SYNC = 1'b1;
      @(negedge CLK);
      ifc.SYNC = 1'b0;
      send_byte(8'hBC, 0);
      @(negedge CLK);
      checks++;
      if (ifc.ATTN1 !== 4'hC || ifc.BYTE_DONE !== 1'b1) begin
         fails++;
         $display("[TB] FAIL sync_attn1: got attn1=%h done=%b, expected C 1",
                  ifc.ATTN1, ifc.BYTE_DONE);
      end
   endtask

   task automatic test_sync_shift;
      int d0;
      logic [7:0] v;
      v = 8'hD6;
      repeat (4) shift_bit(1'b0, 1'b0);
      d0 = done_cnt;
      shift_bit(v[0], 1'b1);
      for (int i = 1; i < 7; i++)
         shift_bit(v[i], 1'b0);
      repeat (3) @(negedge CLK);
      checks++;
      if (done_cnt !== d0 || ifc.ATTN2 !== 4'hF) begin
         fails++;
         $display("[TB] FAIL sync_shift_early: got %0d decodes attn2=%h after 6 shifts, expected 0 F",
                  done_cnt - d0, ifc.ATTN2);
      end
      shift_bit(v[7], 1'b0);
      @(negedge CLK);
      checks++;
      if (ifc.ATTN2 !== 4'h6 || ifc.BYTE_DONE !== 1'b1) begin
         fails++;
         $display("[TB] FAIL sync_shift_decode: got attn2=%h done=%b, expected 6 1",
                  ifc.ATTN2, ifc.BYTE_DONE);
      end
   endtask

   initial begin
      RST          = 1'b1;
      ifc.SHIFT_EN = 1'b0;
      ifc.SYNC     = 1'b0;
      @(negedge CLK);
      test_reset;
      test_reset_midbyte;
      test_tone;
      test_attn;
      test_noise;
      test_gaps;
      test_sync;
      test_sync_shift;
      repeat (2) @(negedge CLK);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

   // Hard stop in case a task never returns.
   initial begin
      #200000;
      $display("[TB] FAIL timeout: simulation did not complete, expected finish before 200000");
      $fatal(1);
   end

endmodule
